// File: rtl/alu_pkg.sv
// Shared command types for the ALU issue stage: opcode encoding and the
// packed command word that travels through the command FIFO.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        op_e        op;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO with a combinational head view, async active-low reset and
// synchronous flush that also discards any push in the flush cycle.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = alu_cmd_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    T              mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    // DEPTH is a power of two, so plain AW-bit increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: FIFO-buffered commands, result register
// on a valid/ready stream. Define ALU_SEQ_STATS_EN to build the issue/overflow counters.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_op_sel,
    input  logic [7:0]       alu_y,
    input  logic             alu_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_y,
    output logic             res_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] ovf_count,
    output logic [CNT_W-1:0] op_count
);

    alu_cmd_t cmd_in;
    alu_cmd_t head;
    logic     full;
    logic     empty;
    logic     push;
    logic     issue;
    logic     res_valid_reg;
    logic [7:0] res_y_reg;
    logic     res_ovf_reg;

    assign cmd_in = '{a: cmd_a, b: cmd_b, op: op_e'(cmd_op)};

    // cmd_ready depends only on the registered FIFO count, never on res_ready.
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign issue     = !empty && (!res_valid_reg || res_ready);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (alu_cmd_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (cmd_in),
        .pop       (issue),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign alu_a      = head.a;
    assign alu_b      = head.b;
    assign alu_op_sel = head.op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_y_reg     <= '0;
            res_ovf_reg   <= 1'b0;
        end else if (flush) begin
            res_valid_reg <= 1'b0;
        end else if (issue) begin
            res_valid_reg <= 1'b1;
            res_y_reg     <= alu_y;
            res_ovf_reg   <= alu_ovf;
        end else if (res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign res_valid = res_valid_reg;
    assign res_y     = res_y_reg;
    assign res_ovf   = res_ovf_reg;
    assign busy      = !empty || res_valid_reg;

`ifdef ALU_SEQ_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] op_count_reg;
    logic [CNT_W-1:0] ovf_count_reg;

    // Flushed issues never produce a result, so they are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg  <= '0;
            ovf_count_reg <= '0;
        end else if (issue && !flush) begin
            if (op_count_reg != CNT_MAX) op_count_reg <= op_count_reg + CNT_W'(1);
            if (alu_ovf && ovf_count_reg != CNT_MAX) ovf_count_reg <= ovf_count_reg + CNT_W'(1);
        end
    end

    assign op_count  = op_count_reg;
    assign ovf_count = ovf_count_reg;
`else
    assign op_count  = '0;
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic [1:0] cmd_op = '0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op_sel;
    logic [7:0] alu_y;
    logic alu_ovf;
    logic res_valid;
    logic res_ready = 1'b0;
    logic [7:0] res_y;
    logic res_ovf;
    logic busy;
    logic [CNT_W-1:0] ovf_count;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel),
        .alu_y(alu_y), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_ovf(res_ovf), .busy(busy),
        .ovf_count(ovf_count), .op_count(op_count)
    );

    // Behavioural ALU: {ovf, y}, ovf is signed overflow for ADD/SUB.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [7:0] y;
        logic       v;
        v = 1'b0;
        case (op)
            2'b00: begin y = a + b; v = (a[7] == b[7]) && (y[7] != a[7]); end
            2'b01: begin y = a - b; v = (a[7] != b[7]) && (y[7] != a[7]); end
            2'b10: y = a & b;
            default: y = a | b;
        endcase
        return {v, y};
    endfunction

    assign {alu_ovf, alu_y} = alu_f(alu_a, alu_b, alu_op_sel);

    // Reference model: queue of pending commands plus one result slot.
    logic [17:0] m_q[$];
    logic        m_rv;
    logic [7:0]  m_y;
    logic        m_ovf;
    int          m_opc;
    int          m_ovc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_rv = 1'b0; m_y = '0; m_ovf = 1'b0; m_opc = 0; m_ovc = 0;
        end else begin
            logic do_issue;
            logic do_push;
            logic [8:0] r;
            do_issue = (m_q.size() != 0) && (!m_rv || res_ready);
            do_push  = cmd_valid && (m_q.size() < DEPTH);
            if (flush) begin
                m_q.delete();
                m_rv = 1'b0;
            end else begin
                if (do_issue) begin
                    r = alu_f(m_q[0][17:10], m_q[0][9:2], m_q[0][1:0]);
                    m_y = r[7:0]; m_ovf = r[8]; m_rv = 1'b1;
                    void'(m_q.pop_front());
                    if (m_opc < 15) m_opc++;
                    if (r[8] && m_ovc < 15) m_ovc++;
                end else if (m_rv && res_ready) begin
                    m_rv = 1'b0;
                end
                if (do_push) m_q.push_back({cmd_a, cmd_b, cmd_op});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
        check("res_valid", 32'(res_valid), 32'(m_rv));
        check("busy", 32'(busy), 32'((m_q.size() != 0) || m_rv));
        if (m_rv) begin
            check("res_y", 32'(res_y), 32'(m_y));
            check("res_ovf", 32'(res_ovf), 32'(m_ovf));
        end
`ifdef ALU_SEQ_STATS_EN
        check("op_count", 32'(op_count), 32'(m_opc));
        check("ovf_count", 32'(ovf_count), 32'(m_ovc));
`else
        check("op_count", 32'(op_count), 32'd0);
        check("ovf_count", 32'(ovf_count), 32'd0);
`endif
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    endtask

    initial begin
        logic [7:0] got_y[$];
        int acc;

        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("reset_res_y", 32'(res_y), 32'h0);

        // Single ADD: result visible two edges after acceptance.
        res_ready = 1'b1;
        drive(8'h0F, 8'h01, 2'b00);
        step();
        cmd_valid = 1'b0;
        check("lat_not_yet", 32'(res_valid), 32'd0);
        step();
        check("add_valid", 32'(res_valid), 32'd1);
        check("add_y", 32'(res_y), 32'h10);
        step();

        // Back-to-back SUB/AND/OR.
        drive(8'h05, 8'h07, 2'b01); step();
        drive(8'hF0, 8'h3C, 2'b10); step();
        if (res_valid) got_y.push_back(res_y);
        drive(8'h0A, 8'h50, 2'b11); step();
        if (res_valid) got_y.push_back(res_y);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (res_valid) got_y.push_back(res_y);
        end
        check("b2b_count", 32'(got_y.size()), 32'd3);
        if (got_y.size() == 3) begin
            check("b2b_sub", 32'(got_y[0]), 32'hFE);
            check("b2b_and", 32'(got_y[1]), 32'h30);
            check("b2b_or", 32'(got_y[2]), 32'h5A);
        end

        // Backpressure: DEPTH+1 accepts before cmd_ready drops, result held.
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(8'(i + 1), 8'h10, 2'b00);
            if (cmd_ready) acc++;
            step();
        end
        cmd_valid = 1'b0;
        check("full_accepts", 32'(acc), 32'(DEPTH + 1));
        check("held_y", 32'(res_y), 32'h11);
        step();
        check("held_y2", 32'(res_y), 32'h11);
        res_ready = 1'b1;
        got_y.delete();
        for (int i = 0; i < 8; i++) begin
            if (res_valid) got_y.push_back(res_y);
            step();
        end
        check("drain_count", 32'(got_y.size()), 32'(DEPTH + 1));
        foreach (got_y[i]) check("drain_order", 32'(got_y[i]), 32'(8'(i + 1) + 8'h10));

        // Flush with a held result and queued commands.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin drive(8'h20, 8'(i), 2'b11); step(); end
        cmd_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_res_valid", 32'(res_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_cmd_ready", 32'(cmd_ready), 32'd1);
        res_ready = 1'b1;
        repeat (3) step();

        // Async reset mid-burst.
        for (int i = 0; i < 3; i++) begin drive(8'h7F, 8'(i), 2'b00); step(); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_res_y", 32'(res_y), 32'd0);
        check("arst_op_count", 32'(op_count), 32'd0);
        cmd_valid = 1'b0;
        step();
        rst_n = 1'b1;
        drive(8'h01, 8'h01, 2'b00); step();
        cmd_valid = 1'b0; step();
        check("post_rst_valid", 32'(res_valid), 32'd1);
        check("post_rst_y", 32'(res_y), 32'h02);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 99) < 70);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_op    = 2'($urandom);
            res_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 3);
            step();
        end
        cmd_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
        repeat (8) step();
        check("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
